// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data-memory bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
  parameter int WIDTH = 32
);
  logic             dmem_req_out;
  logic             dmem_we_out;
  logic [WIDTH-1:0] dmem_addr_out;
  logic [WIDTH-1:0] dmem_wdata_out;
  logic [3:0]       dmem_be_out;
  logic             dmem_ack_in;
  logic [WIDTH-1:0] dmem_rdata_in;
  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out,
    input  dmem_ack_in, dmem_rdata_in
  );
  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out,
    output dmem_ack_in, dmem_rdata_in
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32 MEM stage issuing req/ack data-memory transactions, stalling until done,
// extending load data and forwarding writeback fields to MEM/WB.
module mem_access_stage #(
  parameter int WIDTH   = 32,
  parameter int INDEX   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               flush_in,
  input  logic               valid_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic [2:0]         funct3_in,
  input  logic               mem_to_reg_in,
  input  logic               reg_write_in,
  input  logic [INDEX-1:0]   rd_in,
  input  logic [WIDTH-1:0]   alu_res_in,
  input  logic [WIDTH-1:0]   store_data_in,
  mem_access_stage_if.master dmem,
  output logic               stall_out,
  output logic               mem_to_reg_out,
  output logic               reg_write_out,
  output logic [INDEX-1:0]   rd_out,
  output logic [WIDTH-1:0]   alu_res_out,
  output logic [WIDTH-1:0]   data_mem_out,
  output logic               misalign_out,
  output logic               bus_err_out
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             kill_q, req_q, we_q, bus_err_q;
  logic [WIDTH-1:0] addr_q, wdata_q, data_q, wdata_d, data_d;
  logic [3:0]       be_q, be_d;
  logic [1:0]       sz, lane;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;
  logic             access, f3_ok, aligned, bad, go, idle, resp, tmo;
  assign sz      = funct3_in[1:0];
  assign lane    = alu_res_in[1:0];
  assign access  = valid_in & (mem_read_in | mem_write_in) & ~flush_in;
  assign f3_ok   = mem_write_in ? ~funct3_in[2] & (sz != 2'b11)
                                : (sz != 2'b11) & ~(funct3_in[2] & sz[1]);
  assign aligned = sz == 2'b01 ? ~lane[0] : sz == 2'b10 ? lane == 2'b00 : 1'b1;
  assign bad     = ~f3_ok | ~aligned;
  assign idle    = state_q == IDLE;
  assign resp    = state_q == RESP;
  assign go      = idle & access & ~bad;
  assign tmo     = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
  // Store data is replicated into every lane so the byte enables alone select the target bytes
  assign be_d    = !mem_write_in ? 4'b1111 : sz == 2'b00 ? 4'b0001 << lane
                 : sz == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_d = sz == 2'b00 ? {4{store_data_in[7:0]}}
                 : sz == 2'b01 ? {2{store_data_in[15:0]}} : store_data_in;
  assign ld_b    = dmem.dmem_rdata_in[{lane, 3'b000} +: 8];
  assign ld_h    = dmem.dmem_rdata_in[{lane[1], 4'b0000} +: 16];
  assign data_d  = funct3_in == 3'b000 ? {{24{ld_b[7]}}, ld_b}
                 : funct3_in == 3'b001 ? {{16{ld_h[15]}}, ld_h}
                 : funct3_in == 3'b100 ? {24'b0, ld_b}
                 : funct3_in == 3'b101 ? {16'b0, ld_h} : dmem.dmem_rdata_in;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kill_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      data_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: if (go) begin
          state_q <= REQ;
          cnt_q   <= '0;
          kill_q  <= 1'b0;
          req_q   <= 1'b1;
          we_q    <= mem_write_in;
          addr_q  <= {alu_res_in[WIDTH-1:2], 2'b00};
          wdata_q <= wdata_d;
          be_q    <= be_d;
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (flush_in) kill_q <= 1'b1;
          if (dmem.dmem_ack_in || tmo) begin
            state_q <= RESP;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
          end
          if (dmem.dmem_ack_in && !we_q) data_q <= data_d;
          if (!dmem.dmem_ack_in && tmo) begin
            bus_err_q <= 1'b1;
            kill_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          kill_q  <= 1'b0;
        end
      endcase
    end
  assign dmem.dmem_req_out   = req_q;
  assign dmem.dmem_we_out    = we_q;
  assign dmem.dmem_addr_out  = addr_q;
  assign dmem.dmem_wdata_out = wdata_q;
  assign dmem.dmem_be_out    = be_q;
  // Combinational outputs are gated by reset so nothing leaks into MEM/WB while it is held
  assign stall_out      = rst_in & (go | state_q == REQ);
  assign misalign_out   = rst_in & idle & access & bad;
  assign mem_to_reg_out = rst_in & ~stall_out & mem_to_reg_in;
  assign reg_write_out  = rst_in & ~stall_out & reg_write_in & ~flush_in & ~misalign_out & ~(resp & kill_q);
  assign rd_out         = rst_in ? rd_in : '0;
  assign alu_res_out    = rst_in ? alu_res_in : '0;
  assign data_mem_out   = data_q;
  assign bus_err_out    = bus_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized scoreboard bench for mem_access_stage against a lane-arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_access_stage;
  localparam int TMO = 4;
  logic        clk_in = 1'b0, rst_in = 1'b0, flush_in = 1'b0, valid_in = 1'b0;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0, mem_to_reg_in = 1'b0, reg_write_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] alu_res_in = '0, store_data_in = '0;
  logic        stall_out, mem_to_reg_out, reg_write_out, misalign_out, bus_err_out;
  logic [4:0]  rd_out;
  logic [31:0] alu_res_out, data_mem_out;
  mem_access_stage_if #(.WIDTH(32)) bus();
  mem_access_stage #(.WIDTH(32), .INDEX(5), .TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .valid_in(valid_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .funct3_in(funct3_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .rd_in(rd_in),
    .alu_res_in(alu_res_in), .store_data_in(store_data_in), .dmem(bus.master),
    .stall_out(stall_out), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .rd_out(rd_out), .alu_res_out(alu_res_out), .data_mem_out(data_mem_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {
    bit req; bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
    bit chk_data; logic [31:0] data; bit rw; bit m2r; bit mis; bit berr;
    logic [4:0] rd; logic [31:0] alu; int stalls;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  int   nvec = 0, nerr = 0;
  bit   mon_en = 1'b0, req_seen = 1'b0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endfunction
  function automatic exp_t model(bit r, bit w, logic [2:0] f3, logic [31:0] a, logic [31:0] sd,
                                 logic [31:0] rdat, bit fl, int delay, int fl_at, bit m2r, bit rw,
                                 logic [4:0] rdx);
    exp_t e;
    int sz, last;
    bit ok, acked, killed;
    longint v;
    sz     = int'(f3) % 4;
    ok     = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.mis  = (r || w) && !fl && !(ok && (a % (32'd1 << sz)) == 0);
    e.req  = (r || w) && !fl && !e.mis;
    acked  = delay >= 1 && delay <= TMO;
    last   = acked ? delay : TMO;
    e.berr = e.req && !acked;
    killed = e.berr || (e.req && fl_at >= 1 && fl_at <= last);
    e.stalls = e.req ? last + 1 : 0;
    e.we    = w;
    e.addr  = a - a % 4;
    e.be    = !w ? 4'hF : sz == 0 ? 4'(1 << (a % 4)) : sz == 1 ? 4'(3 << (a % 4)) : 4'hF;
    e.wdata = sz == 0 ? (sd & 32'hFF) * 32'h0101_0101 : sz == 1 ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
    if (sz == 0) begin
      v = longint'((rdat >> (8 * (a % 4))) & 32'hFF);
      if (f3 == 3'd0 && v >= 128) v -= 256;
    end else if (sz == 1) begin
      v = longint'((rdat >> (16 * ((a / 2) % 2))) & 32'hFFFF);
      if (f3 == 3'd1 && v >= 32768) v -= 65536;
    end else v = longint'(rdat);
    e.data     = 32'(v);
    e.chk_data = e.req && !w && acked && !killed;
    e.rw  = rw && !fl && !e.mis && !killed;
    e.m2r = m2r;
    e.rd  = rdx;
    e.alu = a;
    return e;
  endfunction
  always @(negedge clk_in) if (mon_en) begin
    if (stall_out) begin
      chk("bubble_reg_write", 32'(reg_write_out), 32'd0);
      chk("bubble_mem_to_reg", 32'(mem_to_reg_out), 32'd0);
      chk("stall_misalign", 32'(misalign_out), 32'd0);
      chk("stall_bus_err", 32'(bus_err_out), 32'd0);
    end
    if (bus.dmem_req_out) begin
      if (sb.size() == 0) chk("req_without_op", 32'(bus.dmem_req_out), 32'd0);
      else begin
        chk("req_expected", 32'(bus.dmem_req_out), 32'(sb[0].req));
        chk("we", 32'(bus.dmem_we_out), 32'(sb[0].we));
        chk("addr", bus.dmem_addr_out, sb[0].addr);
        chk("be", 32'(bus.dmem_be_out), 32'(sb[0].be));
        if (sb[0].we) chk("wdata", bus.dmem_wdata_out, sb[0].wdata);
        req_seen = 1'b1;
      end
    end
    if (valid_in && !stall_out) begin
      if (sb.size() == 0) chk("retire_sb_nonempty", 32'(sb.size()), 32'd1);
      else begin
        me = sb.pop_front();
        chk("req_issued", 32'(req_seen), 32'(me.req));
        chk("misalign", 32'(misalign_out), 32'(me.mis));
        chk("bus_err", 32'(bus_err_out), 32'(me.berr));
        chk("reg_write", 32'(reg_write_out), 32'(me.rw));
        chk("mem_to_reg", 32'(mem_to_reg_out), 32'(me.m2r));
        chk("rd", 32'(rd_out), 32'(me.rd));
        chk("alu_res", alu_res_out, me.alu);
        if (me.chk_data) chk("data_mem", data_mem_out, me.data);
        req_seen = 1'b0;
      end
    end
  end
  task automatic run_op(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdat, input bit fl,
                        input int delay, input int fl_at, input bit m2r, input bit rw);
    exp_t e;
    int   stalls = 0, reqn = 0;
    bit   done = 1'b0;
    logic [4:0] rdx;
    rdx = 5'($urandom);
    e = model(r, w, f3, a, sd, rdat, fl, delay, fl_at, m2r, rw, rdx);
    sb.push_back(e);
    valid_in = 1'b1; mem_read_in = r; mem_write_in = w; funct3_in = f3; alu_res_in = a;
    store_data_in = sd; flush_in = fl; mem_to_reg_in = m2r; reg_write_in = rw; rd_in = rdx;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (!stall_out) done = 1'b1;
      else begin
        stalls++;
        if (bus.dmem_req_out) begin
          reqn++;
          bus.dmem_ack_in   = (reqn == delay);
          bus.dmem_rdata_in = (reqn == delay) ? rdat : $urandom;
          flush_in          = (reqn == fl_at);
        end
        @(posedge clk_in); #1;
        bus.dmem_ack_in = 1'b0;
        flush_in = 1'b0;
        #1;
      end
    end
    if (!done) chk("stall_bound_expired", 32'(stall_out), 32'd0);
    chk("stall_cycles", 32'(stalls), 32'(e.stalls));
    @(posedge clk_in); #1;
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; flush_in = 1'b0;
    alu_res_in = $urandom; reg_write_in = 1'($urandom);
    repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
  endtask
  initial begin
    bit r, w, fl;
    logic [2:0] f3;
    logic [31:0] a;
    int delay, fl_at;
    bus.dmem_ack_in = 1'b0;
    bus.dmem_rdata_in = '0;
    #12;
    chk("rst_req", 32'(bus.dmem_req_out), 32'd0);
    chk("rst_we", 32'(bus.dmem_we_out), 32'd0);
    chk("rst_be", 32'(bus.dmem_be_out), 32'd0);
    chk("rst_addr", bus.dmem_addr_out, 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_data_mem", data_mem_out, 32'd0);
    chk("rst_bus_err", 32'(bus_err_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    mon_en = 1'b1;
    run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 3, 0, 1, 1);
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 1, 0, 1, 1);
    run_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 2, 0, 1, 1);
    run_op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 1, 0, 0, 0);
    run_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 0, 1, 1);
    run_op(1, 0, 3'b010, 32'h104, 32'h0, 32'h0, 0, 0, 0, 1, 1);
    run_op(1, 0, 3'b010, 32'h108, 32'h0, 32'h1111_2222, 0, 3, 1, 1, 1);
    run_op(1, 0, 3'b010, 32'h10C, 32'h0, 32'h0, 1, 1, 0, 1, 1);
    run_op(1, 0, 3'b001, 32'h10E, 32'h0, 32'h8001_7FFF, 0, TMO, 0, 1, 1);
    run_op(1, 1, 3'b000, 32'h111, 32'hA5A5_A5C3, 32'h0, 0, 2, 0, 0, 1);
    run_op(0, 0, 3'b111, 32'h115, 32'h0, 32'h0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 200; i++) begin
      r = 1'($urandom);
      w = $urandom_range(0, 2) == 0;
      if (!r && !w && $urandom_range(0, 3) != 0) r = 1'b1;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      fl = $urandom_range(0, 15) == 0;
      delay = $urandom_range(0, 6);
      fl_at = $urandom_range(0, 5) == 0 ? $urandom_range(1, TMO) : 0;
      run_op(r, w, f3, a, $urandom, $urandom, fl, delay, fl_at, 1'($urandom), 1'($urandom));
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    @(posedge clk_in); #1;
    valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010;
    alu_res_in = 32'h200; reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
    @(posedge clk_in); #1;
    chk("midreq_req", 32'(bus.dmem_req_out), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("midreq_rst_req", 32'(bus.dmem_req_out), 32'd0);
    chk("midreq_rst_be", 32'(bus.dmem_be_out), 32'd0);
    chk("midreq_rst_stall", 32'(stall_out), 32'd0);
    chk("midreq_rst_reg_write", 32'(reg_write_out), 32'd0);
    chk("midreq_rst_mem_to_reg", 32'(mem_to_reg_out), 32'd0);
    chk("midreq_rst_alu_res", alu_res_out, 32'd0);
    chk("midreq_rst_data_mem", data_mem_out, 32'd0);
    chk("midreq_rst_misalign", 32'(misalign_out), 32'd0);
    valid_in = 1'b0; mem_read_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("post_rst_req", 32'(bus.dmem_req_out), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
